cmp2_share_arbiter: RTL and testbench

- Shares one two_bit_comparator instance between NREQ requesters.
- A round-robin arbiter grants one requester at a time. A 3-state FSM then sequences each request through latch, evaluate and respond.
- Sits between requester logic and the comparator. Requesters never drive the comparator directly.

---
 rtl/cmp2_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_cmp2_share_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cmp2_share_arbiter.sv
// cmp2_share_arbiter: one two_bit_comparator shared by NREQ requesters.
// A round-robin pick in StIdle latches the winner's operands, StEval registers the
// compare result and raises done, StDone shows the result for one cycle and rotates
// the pointer past the winner.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   req_i       level request per requester, held until its done bit
//   op_a_i      operand A per requester, requester i uses op_a_i[2i+1:2i]
//   op_b_i      operand B per requester, same packing
//   gnt_o       one-hot grant, high in StEval and StDone
//   done_o      one-hot one-cycle completion pulse
//   rsp_gt_o    A > B, valid while done_o != 0
//   rsp_eq_o    A == B, valid while done_o != 0
//   rsp_lt_o    A < B, valid while done_o != 0
//   busy_o      FSM not idle
//   op_count_o  completed operations, wraps silently

module two_bit_comparator (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic f1,
  output logic f2,
  output logic f3
);
  logic hi_eq;

  assign hi_eq = ~(a1 ^ b1);
  assign f1    = (a1 & ~b1) | (hi_eq & a0 & ~b0);
  assign f2    = hi_eq & ~(a0 ^ b0);
  assign f3    = (~a1 & b1) | (hi_eq & ~a0 & b0);
endmodule

module cmp2_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [2*NREQ-1:0]  op_a_i,
  input  logic [2*NREQ-1:0]  op_b_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               rsp_gt_o,
  output logic               rsp_eq_o,
  output logic               rsp_lt_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   op_count_o
);
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [1:0]        opa_q, opa_d;
  logic [1:0]        opb_q, opb_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              gt_q, gt_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmp_gt, cmp_eq, cmp_lt;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW:0]     cand;
  logic [PtrW-1:0]   ptr_next;

  // Comparator sees only the latched operands, never the live request inputs.
  two_bit_comparator u_cmp (
    .a1 (opa_q[1]),
    .a0 (opa_q[0]),
    .b1 (opb_q[1]),
    .b0 (opb_q[0]),
    .f1 (cmp_gt),
    .f2 (cmp_eq),
    .f3 (cmp_lt)
  );

  // Round-robin scan starting at ptr_q; cand is one bit wider so the mod-NREQ wrap
  // works for non-power-of-two NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NREQ)) begin
        cand = cand - (PtrW+1)'(NREQ);
      end
      if (!win_found && req_i[cand[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PtrW-1:0];
      end
    end
  end

  assign ptr_next = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + PtrW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          win_d   = win_idx;
          opa_d   = op_a_i[{win_idx, 1'b0} +: 2];
          opb_d   = op_b_i[{win_idx, 1'b0} +: 2];
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          state_d = StEval;
        end
      end
      StEval: begin
        gt_d    = cmp_gt;
        eq_d    = cmp_eq;
        lt_d    = cmp_lt;
        done_d  = gnt_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StDone;
      end
      StDone: begin
        done_d  = '0;
        gt_d    = 1'b0;
        eq_d    = 1'b0;
        lt_d    = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign rsp_gt_o   = gt_q;
  assign rsp_eq_o   = eq_q;
  assign rsp_lt_o   = lt_q;
  assign busy_o     = busy_q;
  assign op_count_o = cnt_q;
endmodule

// File: tb/tb_cmp2_share_arbiter.sv
// Directed bench for cmp2_share_arbiter (NREQ=4, CNT_W=8). Outputs are sampled on
// the falling edge; inputs are driven on the falling edge.
module tb_cmp2_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic [3:0] gnt, done;
  logic       rsp_gt, rsp_eq, rsp_lt, busy;
  logic [7:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp2_share_arbiter #(.NREQ(4), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .gnt_o      (gnt),
    .done_o     (done),
    .rsp_gt_o   (rsp_gt),
    .rsp_eq_o   (rsp_eq),
    .rsp_lt_o   (rsp_lt),
    .busy_o     (busy),
    .op_count_o (op_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rsp(input logic [1:0] a, input logic [1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // One isolated request; called and returns at a falling edge with the FSM idle.
  task automatic run_op(input int idx, input logic [1:0] a, input logic [1:0] b,
                        output logic [3:0] g1, output logic [3:0] d2,
                        output logic [2:0] r2, output logic [2:0] s3);
    req = '0;
    req[idx] = 1'b1;
    op_a[2*idx +: 2] = a;
    op_b[2*idx +: 2] = b;
    @(posedge clk); @(negedge clk);
    g1 = gnt;
    @(posedge clk); @(negedge clk);
    d2 = done;
    r2 = {rsp_gt, rsp_eq, rsp_lt};
    req = '0;
    @(posedge clk); @(negedge clk);
    s3 = {busy, |done, |gnt};
  endtask

  initial begin
    logic [3:0] g1, d2;
    logic [2:0] r2, s3;
    logic       stray;
    int         order[$];
    int         exp_order[5];

    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    #12;
    check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("rst_done", {28'd0, done}, 32'd0);
    check_eq("rst_rsp", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cnt", {24'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: 3 > 1
    run_op(0, 2'd3, 2'd1, g1, d2, r2, s3);
    check_eq("single_gnt", {28'd0, g1}, 32'h1);
    check_eq("single_done", {28'd0, d2}, 32'h1);
    check_eq("single_rsp", {29'd0, r2}, 32'h4);
    check_eq("single_idle", {29'd0, s3}, 32'h0);
    check_eq("single_cnt", {24'd0, op_count}, 32'd1);

    // All 16 operand pairs on requester 2
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op(2, 2'(a), 2'(b), g1, d2, r2, s3);
        check_eq($sformatf("exh_done_%0d_%0d", a, b), {28'd0, d2}, 32'h4);
        check_eq($sformatf("exh_rsp_%0d_%0d", a, b), {29'd0, r2},
                 {29'd0, exp_rsp(2'(a), 2'(b))});
        check_eq($sformatf("exh_idle_%0d_%0d", a, b), {29'd0, s3}, 32'h0);
      end
    end
    check_eq("exh_cnt", {24'd0, op_count}, 32'd17);

    // Reset in the middle of an operation on requester 1
    req = 4'b0010;
    op_a[3:2] = 2'd2;
    op_b[3:2] = 2'd1;
    @(posedge clk); @(negedge clk);
    check_eq("mid_gnt", {28'd0, gnt}, 32'h2);
    rst_n = 1'b0;
    req = '0;
    #1;
    check_eq("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_cnt", {24'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      stray = stray | (|done) | busy | rsp_gt | rsp_eq | rsp_lt;
    end
    check_eq("mid_no_done", {31'd0, stray}, 32'd0);
    check_eq("mid_cnt_after", {24'd0, op_count}, 32'd0);

    // Fairness: all four requesting continuously from ptr=0
    op_a = 8'b11_10_01_00;
    op_b = 8'b01_01_01_01;
    req  = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          order.push_back(i);
          check_eq($sformatf("fair_rsp_%0d", c), {29'd0, rsp_gt, rsp_eq, rsp_lt},
                   {29'd0, exp_rsp(op_a[2*i +: 2], op_b[2*i +: 2])});
        end
      end
    end
    req = '0;
    check_eq("fair_len", order.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) begin
        check_eq($sformatf("fair_order_%0d", i), order[i], exp_order[i]);
      end
    end
    check_eq("fair_cnt", {24'd0, op_count}, 32'd5);
    @(posedge clk); @(negedge clk);

    // Operand change after the latch edge is ignored
    req = 4'b0001;
    op_a[1:0] = 2'd1;
    op_b[1:0] = 2'd1;
    @(posedge clk); @(negedge clk);
    op_a[1:0] = 2'd3;
    @(posedge clk); @(negedge clk);
    check_eq("late_done", {28'd0, done}, 32'h1);
    check_eq("late_rsp", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h2);
    req = '0;
    @(posedge clk); @(negedge clk);
    check_eq("late_cnt", {24'd0, op_count}, 32'd6);

    // Counter wrap
    for (int i = 6; i < 255; i++) begin
      run_op(i % 4, 2'(i % 4), 2'((i / 4) % 4), g1, d2, r2, s3);
    end
    check_eq("wrap_pre", {24'd0, op_count}, 32'd255);
    run_op(3, 2'd2, 2'd1, g1, d2, r2, s3);
    check_eq("wrap_done", {28'd0, d2}, 32'h8);
    check_eq("wrap_rsp", {29'd0, r2}, 32'h4);
    check_eq("wrap_idle", {29'd0, s3}, 32'h0);
    check_eq("wrap_cnt", {24'd0, op_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
